// File: rtl/pio_ws2812_tx.sv
// Serialises a 24-bit colour word onto a WS2812-style single-wire LED chain.
// Optional periodic resend of the held colour: define WS2812_AUTO_REFRESH_EN.
module pio_ws2812_tx #(
    parameter int unsigned NUM_LEDS    = 1,
    parameter int unsigned BIT_CYC     = 62,
    parameter int unsigned T0H_CYC     = 20,
    parameter int unsigned T1H_CYC     = 40,
    parameter int unsigned LATCH_CYC   = 15000,
    parameter int unsigned REFRESH_CYC = 2500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] color_in,
    output logic        ws_dout,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned CNT_MAX = (BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned LED_W   = $clog2(NUM_LEDS + 1);
    localparam int unsigned IDX_W   = 5;

    generate
        if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_timing
            $error("pio_ws2812_tx: require 0 < T0H_CYC < T1H_CYC < BIT_CYC");
        end
        if (LATCH_CYC < 1 || NUM_LEDS < 1 || REFRESH_CYC < 1) begin : g_bad_count
            $error("pio_ws2812_tx: LATCH_CYC, NUM_LEDS and REFRESH_CYC must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [23:0]        shadow;
    logic               first_pending;
    logic [IDX_W-1:0]   bit_idx;
    logic [LED_W-1:0]   led_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   high_last;
    logic [CNT_W-1:0]   low_last;
    logic               cur_bit;
    logic               high_end;
    logic               low_end;
    logic               latch_end;
    logic               last_bit;
    logic               refresh_due;
    logic               start_c;
    logic               ws_dout_nxt;
    logic               busy_nxt;
    logic               frame_done_nxt;

    assign cur_bit   = shadow[bit_idx];
    assign high_last = cur_bit ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
    assign low_last  = cur_bit ? CNT_W'(BIT_CYC - T1H_CYC - 1) : CNT_W'(BIT_CYC - T0H_CYC - 1);
    assign high_end  = (cnt == high_last);
    assign low_end   = (cnt == low_last);
    assign latch_end = (cnt == CNT_W'(LATCH_CYC - 1));
    assign last_bit  = (bit_idx == '0) && (led_cnt == LED_W'(NUM_LEDS - 1));

`ifdef WS2812_AUTO_REFRESH_EN
    localparam int unsigned REF_W = $clog2(REFRESH_CYC + 1);

    logic [REF_W-1:0] refresh_cnt;

    // Counts idle cycles only; any frame start restarts the interval.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
        end else if (state != IDLE || start_c) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign refresh_due = (refresh_cnt == REF_W'(REFRESH_CYC - 1));
`else
    assign refresh_due = 1'b0;
`endif

    assign start_c = (color_in != shadow) || first_pending || refresh_due;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ws_dout    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            ws_dout    <= ws_dout_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_c)   state_nxt = HIGH;
            HIGH:    if (high_end)  state_nxt = LOW;
            LOW:     if (low_end)   state_nxt = last_bit ? LATCH : HIGH;
            LATCH:   if (latch_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ws_dout_nxt    = 1'b0;
        busy_nxt       = 1'b0;
        frame_done_nxt = 1'b0;
        ws_dout_nxt    = (state_nxt == HIGH);
        busy_nxt       = (state_nxt != IDLE);
        frame_done_nxt = (state == LATCH) && latch_end;
    end

    // Frame datapath: colour snapshot, bit/LED position and phase timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow        <= '0;
            first_pending <= 1'b1;
            bit_idx       <= IDX_W'(23);
            led_cnt       <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_c) begin
                        shadow        <= color_in;
                        first_pending <= 1'b0;
                        bit_idx       <= IDX_W'(23);
                        led_cnt       <= '0;
                        cnt           <= '0;
                    end
                end
                HIGH: cnt <= high_end ? '0 : cnt + 1'b1;
                LOW: begin
                    if (low_end) begin
                        cnt <= '0;
                        if (bit_idx == '0) begin
                            bit_idx <= IDX_W'(23);
                            led_cnt <= led_cnt + 1'b1;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LATCH: cnt <= latch_end ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_ws2812_tx.sv
// Bench for pio_ws2812_tx: frame-timeline model checked every cycle plus literal pulse-width checks.
module tb_pio_ws2812_tx;

    localparam int NUM_LEDS    = 2;
    localparam int BIT_CYC     = 10;
    localparam int T0H_CYC     = 3;
    localparam int T1H_CYC     = 7;
    localparam int LATCH_CYC   = 20;
    localparam int REFRESH_CYC = 100;
    localparam int DATA_LEN    = NUM_LEDS * 24 * BIT_CYC;
    localparam int FRAME_LEN   = DATA_LEN + LATCH_CYC;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] color_in = 24'hFFFFFF;
    logic        ws_dout;
    logic        busy;
    logic        frame_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    pio_ws2812_tx #(
        .NUM_LEDS   (NUM_LEDS),
        .BIT_CYC    (BIT_CYC),
        .T0H_CYC    (T0H_CYC),
        .T1H_CYC    (T1H_CYC),
        .LATCH_CYC  (LATCH_CYC),
        .REFRESH_CYC(REFRESH_CYC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .color_in  (color_in),
        .ws_dout   (ws_dout),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: position within the current frame (-1 idle, FRAME_LEN = done cycle).
    int          m_t = -1;
    logic [23:0] m_shadow = 24'h0;
    bit          m_first = 1'b1;
    int          m_idle = 0;

    always @(posedge clk or negedge reset_n) begin
        bit refresh_hit;
        if (!reset_n) begin
            m_t = -1;
            m_shadow = 24'h0;
            m_first = 1'b1;
            m_idle = 0;
        end else if (m_t >= 0 && m_t < FRAME_LEN) begin
            m_t = m_t + 1;
        end else begin
`ifdef WS2812_AUTO_REFRESH_EN
            refresh_hit = (m_idle == REFRESH_CYC - 1);
`else
            refresh_hit = 1'b0;
`endif
            if (color_in != m_shadow || m_first || refresh_hit) begin
                m_t = 0;
                m_shadow = color_in;
                m_first = 1'b0;
                m_idle = 0;
            end else begin
                m_t = -1;
                m_idle = m_idle + 1;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        logic e_ws, e_busy, e_done, b;
        int k;
        e_busy = (m_t >= 0 && m_t < FRAME_LEN);
        e_done = (m_t == FRAME_LEN);
        e_ws = 1'b0;
        if (m_t >= 0 && m_t < DATA_LEN) begin
            k = m_t / BIT_CYC;
            b = m_shadow[23 - (k % 24)];
            e_ws = ((m_t % BIT_CYC) < (b ? T1H_CYC : T0H_CYC));
        end
        chk("ws_dout", 32'(ws_dout), 32'(e_ws));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("frame_done", 32'(frame_done), 32'(e_done));
    end

    // Waveform measurements for literal checks.
    int pulses[$];
    int busy_runs[$];
    int lo_runs[$];
    int hi_run = 0;
    int bhi = 0;
    int blo = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (ws_dout === 1'b1) hi_run++;
        else if (hi_run > 0) begin
            pulses.push_back(hi_run);
            hi_run = 0;
        end
        if (busy === 1'b1) begin
            bhi++;
            if (blo > 0) begin
                lo_runs.push_back(blo);
                blo = 0;
            end
        end else begin
            if (bhi > 0) begin
                busy_runs.push_back(bhi);
                bhi = 0;
            end
            blo++;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_meas();
        pulses.delete();
        busy_runs.delete();
        lo_runs.delete();
        hi_run = 0;
        bhi = 0;
        blo = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input int max, input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < max);
        chk(nm, 32'(frame_done), 32'd1);
    endtask

    initial begin
        int a5_w[8];
        a5_w = '{7, 3, 7, 3, 3, 7, 3, 7};

        // 1: reset state, then all-ones frame after release
        repeat (3) step();
        chk("rst_ws", 32'(ws_dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        clear_meas();
        reset_n = 1'b1;
        step();
        chk("t1_rise", 32'(ws_dout), 32'd1);
        wait_done(700, "t1_done_timeout");
        repeat (30) step();
        chk("t1_npulses", 32'(pulses.size()), 32'd48);
        foreach (pulses[i]) chk("t1_width", 32'(pulses[i]), 32'd7);
        chk("t1_nbusy", 32'(busy_runs.size()), 32'd1);
        if (busy_runs.size() > 0) chk("t1_busy_len", 32'(busy_runs[0]), 32'd500);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // 2: A50000 pulse pattern on both LEDs
        clear_meas();
        color_in = 24'hA50000;
        step();
        chk("t2_rise", 32'(ws_dout), 32'd1);
        wait_done(700, "t2_done_timeout");
        repeat (5) step();
        chk("t2_npulses", 32'(pulses.size()), 32'd48);
        if (pulses.size() == 48) begin
            for (int i = 0; i < 8; i++) begin
                chk("t2_led0_hi", 32'(pulses[i]), 32'(a5_w[i]));
                chk("t2_led1_hi", 32'(pulses[24 + i]), 32'(a5_w[i]));
            end
            for (int i = 8; i < 24; i++) begin
                chk("t2_led0_lo", 32'(pulses[i]), 32'd3);
                chk("t2_led1_lo", 32'(pulses[24 + i]), 32'd3);
            end
        end

        // 3: changes mid-frame collapse to one follow-on frame of the latest value
        clear_meas();
        color_in = 24'h123456;
        repeat (100) step();
        color_in = 24'h00FF00;
        repeat (100) step();
        color_in = 24'h0000FF;
        wait_done(700, "t3_done1_timeout");
        wait_done(700, "t3_done2_timeout");
        repeat (5) step();
        chk("t3_done_cnt", 32'(done_cnt), 32'd2);
        chk("t3_npulses", 32'(pulses.size()), 32'd96);
        if (lo_runs.size() > 0) chk("t3_gap", 32'(lo_runs[$]), 32'd1);
        else chk("t3_gap_seen", 32'(lo_runs.size()), 32'd1);
        if (pulses.size() == 96) begin
            chk("t3_f1_b0", 32'(pulses[0]), 32'd3);
            chk("t3_f1_b3", 32'(pulses[3]), 32'd7);
            chk("t3_f2_b0", 32'(pulses[48]), 32'd3);
            for (int i = 16; i < 24; i++) chk("t3_f2_blue", 32'(pulses[48 + i]), 32'd7);
            chk("t3_f2_led1", 32'(pulses[72]), 32'd3);
        end

        // 4: reset during HIGH abandons the frame; full frame after release
        color_in = 24'h0F0F0F;
        repeat (50) step();
        reset_n = 1'b0;
        #1;
        chk("t4_ws_async", 32'(ws_dout), 32'd0);
        chk("t4_busy_async", 32'(busy), 32'd0);
        repeat (3) step();
        reset_n = 1'b1;
        clear_meas();
        wait_done(700, "t4_done_timeout");
        repeat (5) step();
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_npulses", 32'(pulses.size()), 32'd48);
        if (busy_runs.size() > 0) chk("t4_busy_len", 32'(busy_runs[$]), 32'd500);
        if (pulses.size() == 48) begin
            chk("t4_b0", 32'(pulses[0]), 32'd3);
            chk("t4_b4", 32'(pulses[4]), 32'd7);
        end

        // 5: toggle away and back while busy -> no second frame
        clear_meas();
        color_in = 24'h3C3C3C;
        repeat (60) step();
        color_in = 24'h111111;
        repeat (60) step();
        color_in = 24'h3C3C3C;
        wait_done(700, "t5_done_timeout");
        repeat (40) step();
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_nbusy", 32'(busy_runs.size()), 32'd1);
        if (busy_runs.size() > 0) chk("t5_busy_len", 32'(busy_runs[0]), 32'd500);

        // 6: constant colour -> periodic resends only with auto refresh
        clear_meas();
`ifdef WS2812_AUTO_REFRESH_EN
        repeat (1300) step();
        chk("t6_nrises", 32'(lo_runs.size()), 32'd3);
        if (lo_runs.size() >= 2) chk("t6_idle_gap", 32'(lo_runs[$]), 32'd100);
        chk("t6_done_cnt", 32'(done_cnt), 32'd2);
`else
        repeat (300) step();
        chk("t6_no_frame", 32'(bhi + busy_runs.size()), 32'd0);
        chk("t6_done_cnt", 32'(done_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pio_ws2812_tx.md
Name: pio_ws2812_tx

Overview:
- Downstream consumer of the 24-bit PIO colour output: takes a parallel 24-bit colour word and serialises it onto a single-wire WS2812-style LED chain.
- Uses 1-wire NRZ pulse-width timing derived from clk, followed by a latch (reset) low period.
- Sends a new frame whenever the input word changes; the same colour goes to every LED in the chain.
- Sits between the HPS-controlled PIO register and the FPGA pin driving the LED strip.

Parameters:
- NUM_LEDS, 1, LEDs in the chain; each receives the same 24-bit word.
- BIT_CYC, 62, clk cycles per data bit (1.24 us at 50 MHz).
- T0H_CYC, 20, high time in cycles for a '0' bit.
- T1H_CYC, 40, high time in cycles for a '1' bit.
- LATCH_CYC, 15000, low cycles after the last bit (300 us at 50 MHz).
- REFRESH_CYC, 2500000, idle cycles between forced resends; used only with the optional feature.
- Legal ranges: 0 < T0H_CYC < T1H_CYC < BIT_CYC; LATCH_CYC >= 1; NUM_LEDS >= 1. Illegal values are a $error at elaboration.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- color_in  in  24  colour word from PIO out_port; bits [23:16] sent first, MSB-first overall
- ws_dout  out  1  serial data to LED chain
- busy  out  1  high while a frame (bits + latch) is in progress
- frame_done  out  1  one-cycle pulse at the end of each latch period

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values: ws_dout=0, busy=0, frame_done=0, state=IDLE, shadow=0, first_pending=1.
- Reset asserted mid-frame: ws_dout is forced low immediately (asynchronously). The frame is abandoned. After release, a fresh frame is sent because first_pending=1.
- States: IDLE, HIGH, LOW, LATCH.
- IDLE:
  - Start condition: (color_in != shadow) OR first_pending.
  - In a cycle where the start condition holds, at the next edge: shadow<=color_in, first_pending<=0, bit index<=23, LED counter<=0, state<=HIGH, ws_dout<=1, busy<=1.
  - Latency: color change to ws_dout rising = 1 clk.
- HIGH:
  - ws_dout=1 for TxH_CYC cycles, where x = shadow[bit index].
  - Then state<=LOW with ws_dout=0.
- LOW:
  - ws_dout=0 for BIT_CYC-TxH_CYC cycles.
  - Then advance: bit index decrements 23->0. After bit 0, the LED counter increments and bit index wraps to 23.
  - After bit 0 of LED NUM_LEDS-1: state<=LATCH. Otherwise: state<=HIGH.
- LATCH:
  - ws_dout=0 for LATCH_CYC cycles.
  - Then state<=IDLE, busy<=0, frame_done=1 for exactly one cycle.
- Frame length: busy is high for exactly NUM_LEDS*24*BIT_CYC + LATCH_CYC cycles.
- color_in changes while busy are ignored for the current frame; shadow is unchanged.
  - On return to IDLE the comparison uses the current color_in, so the latest value is sent (intermediate values are dropped).
  - Back-to-back frames: the first IDLE cycle may start a new frame, so busy drops for exactly 1 cycle.
- A change that returns to the shadow value before IDLE produces no frame.
- Counters are sized with $clog2 of the respective parameter (+1). No wrap-around except bit index and the refresh counter.

Optional Feature:
- Macro: WS2812_AUTO_REFRESH_EN.
- When defined:
  - A refresh counter runs only in IDLE and clears on every frame start.
  - When it reaches REFRESH_CYC-1 it raises the start condition, and a frame of the unchanged shadow is resent. This recovers LEDs after glitches or hot-plug.
  - Counter resets to 0.
- When undefined: no refresh counter is synthesised; frames start only on change or after reset.

Test Plan:
Bench parameters: NUM_LEDS=2, BIT_CYC=10, T0H_CYC=3, T1H_CYC=7, LATCH_CYC=20, REFRESH_CYC=100.
1. Release reset with color_in=24'hFFFFFF -> frame starts 1 clk later; 48 pulses each 7 high / 3 low; busy high 500 cycles; single frame_done pulse; no further activity.
2. Set color_in=24'hA50000 in IDLE -> ws_dout rises 1 clk later; first 8 pulse widths 7,3,7,3,3,7,3,7 high; next 16 are 3 high; the pattern repeats for LED 1; then 20 low.
3. Change color_in to 24'h00FF00 at cycle 100 of a frame, then to 24'h0000FF at cycle 200 -> current frame unchanged; exactly one follow-on frame carrying 24'h0000FF; busy low exactly 1 cycle between frames.
4. Assert reset_n low at cycle 50 of a frame (during HIGH) -> ws_dout=0, busy=0 in the same cycle; after release, a full frame of the current color_in is sent.
5. Toggle color_in away from and back to the shadow value while busy -> no second frame; frame_done pulses once.
6. With WS2812_AUTO_REFRESH_EN and color_in held constant -> identical frames start every 100 IDLE cycles. Without the macro -> no frame after the first.
